// File: rtl/riscv_soft_bypass_ctrl_pkg.sv
// Shared encodings for the ALU source / bypass controls.
// Holds ALU_SRC_*, BYP_SRC_* and the default register index width.
package riscv_soft_bypass_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      ALU_SRC_IMM  = 2'd0,
      ALU_SRC_PC   = 2'd1,
      ALU_SRC_REG  = 2'd2,
      ALU_SRC_ZERO = 2'd3
   } alu_src_e;

   typedef enum logic {
      BYP_SRC_M = 1'b0,
      BYP_SRC_W = 1'b1
   } byp_src_e;

endpackage

// File: rtl/riscv_soft_bypass_ctrl_if.sv
// Decode-side request bundle and X-stage control results.
// master: decoder/pipeline side; slave: bypass controller.
interface riscv_soft_bypass_ctrl_if #(
   parameter int REG_ADDR_W =
      riscv_soft_bypass_ctrl_pkg::REG_ADDR_W
);

   logic                  d_valid;
   logic [REG_ADDR_W-1:0] d_rs1;
   logic [REG_ADDR_W-1:0] d_rs2;
   logic [1:0]            d_sel_a;
   logic [1:0]            d_sel_b;
   logic                  d_wen;
   logic [REG_ADDR_W-1:0] d_rd;
   logic                  d_is_load;
   logic                  d_is_md;
   logic                  flush;

   logic                  stall;
   logic                  x_valid;
   logic                  x_hold;
   logic [1:0]            alu_sel_a;
   logic [1:0]            alu_sel_b;
   logic                  fwd_a;
   logic                  fwd_b;
   logic                  byp_src_a;
   logic                  byp_src_b;

   modport master (
      output d_valid, d_rs1, d_rs2,
      output d_sel_a, d_sel_b,
      output d_wen, d_rd,
      output d_is_load, d_is_md, flush,
      input  stall, x_valid, x_hold,
      input  alu_sel_a, alu_sel_b,
      input  fwd_a, fwd_b,
      input  byp_src_a, byp_src_b
   );

   modport slave (
      input  d_valid, d_rs1, d_rs2,
      input  d_sel_a, d_sel_b,
      input  d_wen, d_rd,
      input  d_is_load, d_is_md, flush,
      output stall, x_valid, x_hold,
      output alu_sel_a, alu_sel_b,
      output fwd_a, fwd_b,
      output byp_src_a, byp_src_b
   );

endinterface

// File: rtl/riscv_soft_hazard_match.sv
// Per-operand hazard match: load-use detect, forward enable, bypass source.
// Ports: sel/rs (operand in D), X and M producer records; load_use/fwd/src out.
module riscv_soft_hazard_match
   import riscv_soft_bypass_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W =
      riscv_soft_bypass_ctrl_pkg::REG_ADDR_W
) (
   input  logic [1:0]            sel,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  x_valid,
   input  logic                  x_wen,
   input  logic                  x_is_load,
   input  logic [REG_ADDR_W-1:0] x_rd,
   input  logic                  m_valid,
   input  logic                  m_wen,
   input  logic [REG_ADDR_W-1:0] m_rd,
   output logic                  load_use,
   output logic                  fwd,
   output logic                  src
);

   logic use_reg;
   logic hit_x;
   logic hit_m;

   // x0 is hardwired, and non-REG selects never read rs
   assign use_reg = (sel == ALU_SRC_REG)
                  && (rs != '0);

   assign hit_x = use_reg && x_valid && x_wen
                && (x_rd == rs);
   assign hit_m = use_reg && m_valid && m_wen
                && (m_rd == rs);

   assign load_use = hit_x && x_is_load;

   // youngest producer wins; W needs nothing
   // since the regfile is write-through
   always_comb begin
      fwd = 1'b0;
      src = BYP_SRC_M;
      if (hit_x && !x_is_load) begin
         fwd = 1'b1;
         src = BYP_SRC_M;
      end else if (hit_m) begin
         fwd = 1'b1;
         src = BYP_SRC_W;
      end
   end

endmodule

// File: rtl/riscv_soft_bypass_ctrl.sv
// Bypass/hazard controller for the two ALU source muxes (D, X, M, W).
// Ports: clk, reset (async, active-high), bus (slave: D request, X controls).
module riscv_soft_bypass_ctrl
   import riscv_soft_bypass_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W =
      riscv_soft_bypass_ctrl_pkg::REG_ADDR_W,
   parameter int MD_LATENCY = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   riscv_soft_bypass_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(MD_LATENCY) + 1;
   localparam logic [CNT_W-1:0] MD_INIT =
      CNT_W'(MD_LATENCY - 1);

   // producer records; W is not tracked because a
   // W-stage producer is served by the write-through regfile
   logic                  x_vld;
   logic                  x_wen;
   logic [REG_ADDR_W-1:0] x_rd;
   logic                  x_ld;
   logic                  m_vld;
   logic                  m_wen;
   logic [REG_ADDR_W-1:0] m_rd;

   logic [CNT_W-1:0]      md_cnt;

   logic [1:0]            sel_a_q;
   logic [1:0]            sel_b_q;
   logic                  fwd_a_q;
   logic                  fwd_b_q;
   logic                  byp_a_q;
   logic                  byp_b_q;

   logic                  lu_a;
   logic                  lu_b;
   logic                  fwd_a_d;
   logic                  fwd_b_d;
   logic                  src_a_d;
   logic                  src_b_d;
   logic                  md_busy;
   logic                  load_use;
   logic                  stall;
   logic                  d_fire;

   riscv_soft_hazard_match #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_match_a (
      .sel       (bus.d_sel_a),
      .rs        (bus.d_rs1),
      .x_valid   (x_vld),
      .x_wen     (x_wen),
      .x_is_load (x_ld),
      .x_rd      (x_rd),
      .m_valid   (m_vld),
      .m_wen     (m_wen),
      .m_rd      (m_rd),
      .load_use  (lu_a),
      .fwd       (fwd_a_d),
      .src       (src_a_d)
   );

   riscv_soft_hazard_match #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_match_b (
      .sel       (bus.d_sel_b),
      .rs        (bus.d_rs2),
      .x_valid   (x_vld),
      .x_wen     (x_wen),
      .x_is_load (x_ld),
      .x_rd      (x_rd),
      .m_valid   (m_vld),
      .m_wen     (m_wen),
      .m_rd      (m_rd),
      .load_use  (lu_b),
      .fwd       (fwd_b_d),
      .src       (src_b_d)
   );

   assign md_busy  = (md_cnt != '0);
   assign load_use = lu_a | lu_b;

   assign stall  = bus.d_valid
                 & (load_use | md_busy)
                 & ~bus.flush;
   assign d_fire = bus.d_valid
                 & ~stall
                 & ~bus.flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_vld   <= 1'b0;
         x_wen   <= 1'b0;
         x_rd    <= '0;
         x_ld    <= 1'b0;
         m_vld   <= 1'b0;
         m_wen   <= 1'b0;
         m_rd    <= '0;
         md_cnt  <= '0;
         sel_a_q <= ALU_SRC_ZERO;
         sel_b_q <= ALU_SRC_ZERO;
         fwd_a_q <= 1'b0;
         fwd_b_q <= 1'b0;
         byp_a_q <= BYP_SRC_M;
         byp_b_q <= BYP_SRC_M;
      end else begin
         // a held md op has not finished, so it
         // never reaches M until the hold ends
         m_vld <= x_vld & ~md_busy;
         m_wen <= x_wen;
         m_rd  <= x_rd;

         if (bus.flush || (!md_busy && !d_fire)) begin
            x_vld   <= 1'b0;
            x_wen   <= 1'b0;
            x_ld    <= 1'b0;
            md_cnt  <= '0;
            sel_a_q <= ALU_SRC_ZERO;
            sel_b_q <= ALU_SRC_ZERO;
            fwd_a_q <= 1'b0;
            fwd_b_q <= 1'b0;
            byp_a_q <= BYP_SRC_M;
            byp_b_q <= BYP_SRC_M;
         end else if (md_busy) begin
            md_cnt <= md_cnt - CNT_W'(1);
         end else begin
            x_vld   <= 1'b1;
            x_wen   <= bus.d_wen;
            x_rd    <= bus.d_rd;
            x_ld    <= bus.d_is_load;
            md_cnt  <= bus.d_is_md ? MD_INIT : '0;
            sel_a_q <= bus.d_sel_a;
            sel_b_q <= bus.d_sel_b;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            byp_a_q <= src_a_d;
            byp_b_q <= src_b_d;
         end
      end
   end

   assign bus.stall     = stall;
   assign bus.x_hold    = md_busy;
   assign bus.x_valid   = x_vld;
   assign bus.alu_sel_a = sel_a_q;
   assign bus.alu_sel_b = sel_b_q;
   assign bus.fwd_a     = fwd_a_q;
   assign bus.fwd_b     = fwd_b_q;
   assign bus.byp_src_a = byp_a_q;
   assign bus.byp_src_b = byp_b_q;

endmodule

// File: tb/tb_riscv_soft_bypass_ctrl.sv
// Scoreboard bench for riscv_soft_bypass_ctrl.
// Driver pushes expected X controls; monitor pops on each X issue.
module tb_riscv_soft_bypass_ctrl;
   import riscv_soft_bypass_ctrl_pkg::*;

   localparam logic [1:0] R  = ALU_SRC_REG;
   localparam logic [1:0] I  = ALU_SRC_IMM;
   localparam logic [1:0] P  = ALU_SRC_PC;
   localparam logic [1:0] Z  = ALU_SRC_ZERO;
   localparam logic       BM = BYP_SRC_M;
   localparam logic       BW = BYP_SRC_W;

   typedef struct packed {
      logic [1:0] sa;
      logic [1:0] sb;
      logic       fa;
      logic       fb;
      logic       ba;
      logic       bb;
      logic [3:0] hold;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   riscv_soft_bypass_ctrl_if bus ();

   riscv_soft_bypass_ctrl #(
      .REG_ADDR_W (5),
      .MD_LATENCY (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   // monitor: one pop per instruction leaving hold in X
   initial begin
      exp_t e;
      int   hold_cnt;
      hold_cnt = 0;
      forever begin
         @(negedge clk);
         if (mon_en && !reset) begin
            if (bus.x_valid && bus.x_hold) begin
               hold_cnt++;
            end else if (bus.x_valid) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL x_issue: got unexpected issue, required none");
               end else begin
                  e = exp_q.pop_front();
                  check("x_ctrl",
                        {bus.alu_sel_a, bus.alu_sel_b,
                         bus.fwd_a, bus.fwd_b,
                         bus.byp_src_a, bus.byp_src_b},
                        {e.sa, e.sb, e.fa, e.fb,
                         e.ba, e.bb});
                  check("hold_cycles", hold_cnt, e.hold);
               end
               hold_cnt = 0;
            end else begin
               check("bubble",
                     {bus.x_hold, bus.alu_sel_a,
                      bus.alu_sel_b, bus.fwd_a, bus.fwd_b},
                     {1'b0, Z, Z, 2'b00});
               hold_cnt = 0;
            end
         end
      end
   end

   task automatic drive(input logic [1:0] sa, sb,
                        input logic [4:0] r1, r2, rd,
                        input logic wen, ld, md);
      bus.d_valid   = 1'b1;
      bus.d_sel_a   = sa;
      bus.d_sel_b   = sb;
      bus.d_rs1     = r1;
      bus.d_rs2     = r2;
      bus.d_rd      = rd;
      bus.d_wen     = wen;
      bus.d_is_load = ld;
      bus.d_is_md   = md;
   endtask

   // holds the instruction in D until it fires, counting stalls
   task automatic issue(input logic [1:0] sa, sb,
                        input logic [4:0] r1, r2, rd,
                        input logic wen, ld, md,
                        input logic fa, fb, ba, bb,
                        input int est,
                        input logic [3:0] eh);
      int n;
      bit st;
      bit done;
      drive(sa, sb, r1, r2, rd, wen, ld, md);
      exp_q.push_back('{sa, sb, fa, fb, ba, bb, eh});
      n = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         st = bus.stall;
         @(posedge clk);
         #1;
         if (!st) begin
            done = 1'b1;
         end else begin
            n++;
            if (n > 16) begin
               tests++;
               fails++;
               $display("FAIL stall_timeout: got %0d stall cycles, required %0d",
                        n, est);
               done = 1'b1;
            end
         end
      end
      check("stall_cycles", n, est);
      bus.d_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.flush = 1'b0;
      drive(Z, Z, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      bus.d_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl",
            {bus.stall, bus.x_hold, bus.x_valid,
             bus.alu_sel_a, bus.alu_sel_b,
             bus.fwd_a, bus.fwd_b,
             bus.byp_src_a, bus.byp_src_b},
            {3'b000, Z, Z, 2'b00, BM, BM});
      @(posedge clk);
      #1;
      reset = 1'b0;
      mon_en = 1'b1;

      // X->M forward, then youngest producer wins
      issue(R, R, 1, 2, 5, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 5, 3, 8, 1, 0, 0, 1, 0, BM, BM, 0, 0);
      issue(R, R, 1, 2, 20, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 1, 2, 20, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 20, 20, 21, 1, 0, 0, 1, 1, BM, BM, 0, 0);

      // M->W forward, then W distance needs none
      issue(R, R, 1, 2, 6, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 1, 1, 9, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 3, 6, 10, 1, 0, 0, 0, 1, BM, BW, 0, 0);
      issue(R, R, 1, 2, 11, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 1, 1, 12, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 1, 1, 13, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 3, 11, 14, 1, 0, 0, 0, 0, BM, BM, 0, 0);

      // load-use: one stall, one bubble, then W forward
      issue(R, I, 1, 0, 7, 1, 1, 0, 0, 0, BM, BM, 0, 0);
      issue(R, I, 7, 7, 15, 1, 0, 0, 1, 0, BW, BM, 1, 0);

      // x0 producer, non-REG selects never match
      issue(R, R, 1, 2, 0, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 0, 0, 16, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 1, 2, 18, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(I, P, 18, 18, 19, 1, 0, 0, 0, 0, BM, BM, 0, 0);
      issue(R, R, 1, 2, 22, 1, 1, 0, 0, 0, BM, BM, 0, 0);
      issue(I, I, 22, 22, 23, 1, 0, 0, 0, 0, BM, BM, 0, 0);

      // mul/div: 3 hold cycles, dependent gets X->M
      issue(R, R, 1, 2, 17, 1, 0, 1, 0, 0, BM, BM, 0, 3);
      issue(R, R, 17, 17, 24, 1, 0, 0, 1, 1, BM, BM, 3, 0);
      issue(R, R, 17, 24, 25, 1, 0, 0, 1, 1, BW, BM, 0, 0);

      // flush during load-use stall
      issue(R, R, 1, 2, 26, 1, 1, 0, 0, 0, BM, BM, 0, 0);
      drive(R, R, 26, 1, 27, 1, 0, 0);
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush_stall", bus.stall, 0);
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      issue(R, R, 26, 1, 27, 1, 0, 0, 1, 0, BW, BM, 0, 0);

      // reset in the middle of an md hold
      drive(R, R, 1, 2, 28, 1, 0, 1);
      @(posedge clk);
      #1;
      drive(R, R, 28, 1, 29, 1, 0, 0);
      @(negedge clk);
      check("hold_stall", bus.stall, 1);
      check("hold_x_hold", bus.x_hold, 1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async",
            {bus.stall, bus.x_hold, bus.x_valid,
             bus.alu_sel_a, bus.alu_sel_b,
             bus.fwd_a, bus.fwd_b,
             bus.byp_src_a, bus.byp_src_b},
            {3'b000, Z, Z, 2'b00, BM, BM});
      bus.d_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      issue(R, R, 28, 1, 30, 1, 0, 0, 0, 0, BM, BM, 0, 0);

      repeat (3) @(negedge clk);
      check("queue_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

endmodule
